// File: rtl/tile_remote_port_if.sv
// Bundles for tile_remote_port: core-facing request/response bus and the
// single shared outgoing request/response bus.
interface tile_core_if #(
    parameter int NumCores  = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    localparam int BeWidth = DataWidth / 8;

    logic [NumCores-1:0]                core_req_i;
    logic [NumCores-1:0]                core_gnt_o;
    logic [NumCores-1:0][AddrWidth-1:0] core_addr_i;
    logic [NumCores-1:0]                core_wen_i;
    logic [NumCores-1:0][DataWidth-1:0] core_wdata_i;
    logic [NumCores-1:0][BeWidth-1:0]   core_be_i;
    logic [NumCores-1:0]                core_vld_o;
    logic [NumCores-1:0][DataWidth-1:0] core_rdata_o;

    modport master (
        output core_req_i, core_addr_i, core_wen_i, core_wdata_i, core_be_i,
        input  core_gnt_o, core_vld_o, core_rdata_o
    );
    modport slave (
        input  core_req_i, core_addr_i, core_wen_i, core_wdata_i, core_be_i,
        output core_gnt_o, core_vld_o, core_rdata_o
    );
endinterface

interface tile_out_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    localparam int BeWidth = DataWidth / 8;

    logic                 out_req_o;
    logic                 out_gnt_i;
    logic [AddrWidth-1:0] out_addr_o;
    logic                 out_wen_o;
    logic [DataWidth-1:0] out_wdata_o;
    logic [BeWidth-1:0]   out_be_o;
    logic                 out_vld_i;
    logic [DataWidth-1:0] out_rdata_i;

    modport master (
        output out_req_o, out_addr_o, out_wen_o, out_wdata_o, out_be_o,
        input  out_gnt_i, out_vld_i, out_rdata_i
    );
    modport slave (
        input  out_req_o, out_addr_o, out_wen_o, out_wdata_o, out_be_o,
        output out_gnt_i, out_vld_i, out_rdata_i
    );
endinterface

// File: rtl/tile_remote_port.sv
// Funnels several core request ports through per-core FIFOs and a round-robin
// arbiter onto one outgoing port; in-order responses are routed back by ID queue.
module tile_remote_port #(
    parameter int NumCores       = 4,
    parameter int ReqDepth       = 2,
    parameter int MaxOutstanding = 8,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    localparam int BeWidth       = DataWidth / 8,
    localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    tile_core_if.slave          core,
    tile_out_if.master          out,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                err_o
);
    localparam int IdxW  = (NumCores > 1) ? $clog2(NumCores) : 1;
    localparam int PtrW  = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int QPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int FillW = $clog2(ReqDepth + 1);
    localparam logic [PtrW-1:0]     PtrLast  = PtrW'(ReqDepth - 1);
    localparam logic [QPtrW-1:0]    QPtrLast = QPtrW'(MaxOutstanding - 1);
    localparam logic [IdxW-1:0]     IdxLast  = IdxW'(NumCores - 1);
    localparam logic [FillW-1:0]    FillMax  = FillW'(ReqDepth);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxOutstanding);

    logic [AddrWidth-1:0] fifo_addr  [NumCores][ReqDepth];
    logic                 fifo_wen   [NumCores][ReqDepth];
    logic [BeWidth-1:0]   fifo_be    [NumCores][ReqDepth];
    logic [DataWidth-1:0] fifo_wdata [NumCores][ReqDepth];
    logic [PtrW-1:0]      wr_ptr     [NumCores];
    logic [PtrW-1:0]      rd_ptr     [NumCores];
    logic [FillW-1:0]     fill       [NumCores];
    logic [NumCores-1:0]  non_empty, push, pop;

    logic [IdxW-1:0]      id_q [MaxOutstanding];
    logic [QPtrW-1:0]     id_wr, id_rd;
    logic [CntWidth-1:0]  outstanding;
    logic [IdxW-1:0]      rr_ptr, rr_pick, winner, held_idx;
    logic                 held_vld, handshake, rsp_ok;

    always_comb begin
        core.core_gnt_o = '0;
        for (int c = 0; c < NumCores; c++) begin
            non_empty[c]       = (fill[c] != '0);
            core.core_gnt_o[c] = rst_ni & core.core_req_i[c] & (fill[c] != FillMax);
        end
    end
    assign push = core.core_gnt_o;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        int c;
        c       = 0;
        rr_pick = rr_ptr;
        for (int i = NumCores - 1; i >= 0; i--) begin
            c = (int'(rr_ptr) + i) % NumCores;
            if (non_empty[c]) rr_pick = IdxW'(c);
        end
    end

    // A presented but ungranted request is held so the payload cannot change.
    assign winner        = held_vld ? held_idx : rr_pick;
    assign out.out_req_o = (|non_empty) && (outstanding != CntMax);
    assign out.out_addr_o  = fifo_addr[winner][rd_ptr[winner]];
    assign out.out_wen_o   = fifo_wen[winner][rd_ptr[winner]];
    assign out.out_be_o    = fifo_be[winner][rd_ptr[winner]];
    assign out.out_wdata_o = fifo_wdata[winner][rd_ptr[winner]];
    assign handshake     = out.out_req_o & out.out_gnt_i;
    assign rsp_ok        = out.out_vld_i & (outstanding != '0);
    assign outstanding_o = outstanding;
    assign core.core_rdata_o = {NumCores{out.out_rdata_i}};

    always_comb begin
        pop             = '0;
        core.core_vld_o = '0;
        if (handshake) pop[winner] = 1'b1;
        if (rsp_ok) core.core_vld_o[id_q[id_rd]] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumCores; c++) begin
            if (push[c]) begin
                fifo_addr[c][wr_ptr[c]]  <= core.core_addr_i[c];
                fifo_wen[c][wr_ptr[c]]   <= core.core_wen_i[c];
                fifo_be[c][wr_ptr[c]]    <= core.core_be_i[c];
                fifo_wdata[c][wr_ptr[c]] <= core.core_wdata_i[c];
            end
        end
        if (handshake) id_q[id_wr] <= winner;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumCores; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                fill[c]   <= '0;
            end
            id_wr       <= '0;
            id_rd       <= '0;
            outstanding <= '0;
            rr_ptr      <= '0;
            held_vld    <= 1'b0;
            held_idx    <= '0;
            err_o       <= 1'b0;
        end else begin
            for (int c = 0; c < NumCores; c++) begin
                if (push[c]) wr_ptr[c] <= (wr_ptr[c] == PtrLast) ? '0 : wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= (rd_ptr[c] == PtrLast) ? '0 : rd_ptr[c] + 1'b1;
                if (push[c] && !pop[c])      fill[c] <= fill[c] + 1'b1;
                else if (pop[c] && !push[c]) fill[c] <= fill[c] - 1'b1;
            end
            if (handshake) begin
                id_wr  <= (id_wr == QPtrLast) ? '0 : id_wr + 1'b1;
                rr_ptr <= (winner == IdxLast) ? '0 : winner + 1'b1;
            end
            if (rsp_ok) id_rd <= (id_rd == QPtrLast) ? '0 : id_rd + 1'b1;
            if (handshake && !rsp_ok)      outstanding <= outstanding + 1'b1;
            else if (rsp_ok && !handshake) outstanding <= outstanding - 1'b1;
            held_vld <= out.out_req_o & ~out.out_gnt_i;
            held_idx <= winner;
            if (out.out_vld_i && outstanding == '0) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tile_remote_port.sv
// Bench for tile_remote_port: directed scenarios plus a randomized run scored
// against a queue-based model of FIFOs, round-robin issue and in-order replies.
module tb_tile_remote_port;
    localparam int NC = 4, RD = 2, MO = 8, AW = 32, DW = 32, BW = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          w;
        logic [BW-1:0] be;
        logic [DW-1:0] d;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] outstanding;
    logic err;
    int errors = 0;
    int checks = 0;

    tile_core_if #(.NumCores(NC), .AddrWidth(AW), .DataWidth(DW)) cif();
    tile_out_if  #(.AddrWidth(AW), .DataWidth(DW)) oif();

    tile_remote_port #(
        .NumCores(NC), .ReqDepth(RD), .MaxOutstanding(MO),
        .AddrWidth(AW), .DataWidth(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .core(cif), .out(oif),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cif.core_req_i   = '0;
        cif.core_addr_i  = '0;
        cif.core_wen_i   = '0;
        cif.core_wdata_i = '0;
        cif.core_be_i    = '1;
        oif.out_gnt_i    = 1'b0;
        oif.out_vld_i    = 1'b0;
        oif.out_rdata_i  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        cif.core_req_i = '1;
        oif.out_vld_i  = 1'b1;
        #2;
        checks++; if (cif.core_gnt_o !== 4'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", cif.core_gnt_o); end
        checks++; if (oif.out_req_o !== 1'b0) begin errors++; $display("FAIL reset_out_req got=%b exp=0", oif.out_req_o); end
        checks++; if (cif.core_vld_o !== 4'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0000", cif.core_vld_o); end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        cif.core_req_i[2] = 1'b1;
        cif.core_addr_i[2] = 32'h100;
        cif.core_wen_i[2] = 1'b0;
        #1;
        checks++; if (cif.core_gnt_o !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", cif.core_gnt_o); end
        checks++; if (oif.out_req_o !== 1'b0) begin errors++; $display("FAIL single_no_comb_req got=%b exp=0", oif.out_req_o); end
        tick();
        cif.core_req_i = '0;
        oif.out_gnt_i = 1'b1;
        #1;
        checks++; if (oif.out_req_o !== 1'b1) begin errors++; $display("FAIL single_out_req got=%b exp=1", oif.out_req_o); end
        checks++; if (oif.out_addr_o !== 32'h100 || oif.out_wen_o !== 1'b0) begin errors++; $display("FAIL single_addr got=%h/%b exp=100/0", oif.out_addr_o, oif.out_wen_o); end
        tick();
        oif.out_gnt_i = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd1 || oif.out_req_o !== 1'b0) begin errors++; $display("FAIL single_issued got=%0d/%b exp=1/0", outstanding, oif.out_req_o); end
        oif.out_vld_i = 1'b1;
        oif.out_rdata_i = 32'hDEADBEEF;
        #1;
        checks++; if (cif.core_vld_o !== 4'b0100) begin errors++; $display("FAIL single_vld got=%b exp=0100", cif.core_vld_o); end
        checks++; if (cif.core_rdata_o[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", cif.core_rdata_o[2]); end
        tick();
        oif.out_vld_i = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd0 || cif.core_vld_o !== 4'b0 || err !== 1'b0) begin errors++; $display("FAIL single_done got=%0d/%b/%b exp=0/0000/0", outstanding, cif.core_vld_o, err); end
    endtask

    task automatic test_fairness();
        int prev, pend_id, w, mx, mn;
        bit pend;
        int served[NC];
        do_reset();
        prev = -1; pend = 0; pend_id = 0; w = 0;
        for (int c = 0; c < NC; c++) served[c] = 0;
        cif.core_req_i = '1;
        oif.out_gnt_i = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < NC; c++) cif.core_addr_i[c] = 32'(c * 256 + n);
            oif.out_vld_i = pend;
            oif.out_rdata_i = 32'(n);
            #1;
            if (pend) begin
                checks++; if (cif.core_vld_o !== 4'(1 << pend_id)) begin errors++; $display("FAIL fair_route got=%b exp_core=%0d", cif.core_vld_o, pend_id); end
            end
            pend = 0;
            if (oif.out_req_o) begin
                w = int'(oif.out_addr_o[9:8]);
                checks++;
                if ((prev < 0 && w != 0) || (prev >= 0 && w != (prev + 1) % NC)) begin
                    errors++; $display("FAIL fair_order got=%0d prev=%0d", w, prev);
                end
                prev = w; served[w]++; pend = 1; pend_id = w;
            end
            tick();
        end
        mx = served[0]; mn = served[0];
        for (int c = 1; c < NC; c++) begin
            if (served[c] > mx) mx = served[c];
            if (served[c] < mn) mn = served[c];
        end
        checks++; if (mx - mn > 1 || mn < 8) begin errors++; $display("FAIL fair_balance got max=%0d min=%0d exp spread<=1", mx, mn); end
        idle();
    endtask

    task automatic test_backpressure();
        int acc[NC];
        req_t head, cur;
        do_reset();
        head = '0;
        for (int c = 0; c < NC; c++) acc[c] = 0;
        oif.out_gnt_i = 1'b0;
        cif.core_req_i = '1;
        for (int n = 0; n < 10; n++) begin
            for (int c = 0; c < NC; c++) begin
                cif.core_addr_i[c]  = $urandom;
                cif.core_wen_i[c]   = 1'($urandom);
                cif.core_be_i[c]    = 4'($urandom);
                cif.core_wdata_i[c] = $urandom;
            end
            if (n == 0) head = {cif.core_addr_i[0], cif.core_wen_i[0], cif.core_be_i[0], cif.core_wdata_i[0]};
            #1;
            for (int c = 0; c < NC; c++) begin
                checks++; if (cif.core_gnt_o[c] !== (acc[c] < RD)) begin errors++; $display("FAIL bp_gnt core=%0d got=%b exp=%b", c, cif.core_gnt_o[c], acc[c] < RD); end
                if (acc[c] < RD) acc[c]++;
            end
            cur = {oif.out_addr_o, oif.out_wen_o, oif.out_be_o, oif.out_wdata_o};
            checks++;
            if (n == 0 && oif.out_req_o !== 1'b0) begin errors++; $display("FAIL bp_req0 got=%b exp=0", oif.out_req_o); end
            else if (n > 0 && (oif.out_req_o !== 1'b1 || cur !== head)) begin
                errors++; $display("FAIL bp_payload got=%b/%h exp=1/%h", oif.out_req_o, cur, head);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_outstanding_cap();
        int hs;
        do_reset();
        hs = 0;
        cif.core_req_i = '1;
        oif.out_gnt_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int c = 0; c < NC; c++) cif.core_addr_i[c] = 32'(c * 256 + n);
            #1;
            if (oif.out_req_o) hs++;
            tick();
        end
        checks++; if (hs != MO) begin errors++; $display("FAIL cap_handshakes got=%0d exp=%0d", hs, MO); end
        checks++; if (outstanding !== 4'd8 || oif.out_req_o !== 1'b0) begin errors++; $display("FAIL cap_full got=%0d/%b exp=8/0", outstanding, oif.out_req_o); end
        oif.out_vld_i = 1'b1;
        oif.out_rdata_i = 32'h55;
        #1;
        checks++; if (cif.core_vld_o !== 4'b0001 || oif.out_req_o !== 1'b0) begin errors++; $display("FAIL cap_rsp got=%b/%b exp=0001/0", cif.core_vld_o, oif.out_req_o); end
        tick();
        oif.out_vld_i = 1'b0;
        #1;
        checks++; if (oif.out_req_o !== 1'b1 || outstanding !== 4'd7) begin errors++; $display("FAIL cap_ninth got=%b/%0d exp=1/7", oif.out_req_o, outstanding); end
        tick();
        checks++; if (oif.out_req_o !== 1'b0 || outstanding !== 4'd8) begin errors++; $display("FAIL cap_refull got=%b/%0d exp=0/8", oif.out_req_o, outstanding); end
        idle();
    endtask

    task automatic test_order_error();
        int ids[3];
        ids[0] = 3; ids[1] = 0; ids[2] = 3;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            cif.core_req_i = '0;
            cif.core_req_i[ids[j]] = 1'b1;
            cif.core_addr_i[ids[j]] = 32'hA00 + 32'(j);
            tick();
            cif.core_req_i = '0;
            oif.out_gnt_i = 1'b1;
            #1;
            checks++; if (oif.out_req_o !== 1'b1 || oif.out_addr_o !== 32'hA00 + 32'(j)) begin errors++; $display("FAIL ord_issue%0d got=%b/%h", j, oif.out_req_o, oif.out_addr_o); end
            tick();
            oif.out_gnt_i = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            oif.out_vld_i = 1'b1;
            oif.out_rdata_i = 32'hC0DE0000 + 32'(j);
            #1;
            checks++;
            if (cif.core_vld_o !== 4'(1 << ids[j]) || cif.core_rdata_o[ids[j]] !== 32'hC0DE0000 + 32'(j)) begin
                errors++; $display("FAIL ord_rsp%0d got=%b/%h exp_core=%0d", j, cif.core_vld_o, cif.core_rdata_o[ids[j]], ids[j]);
            end
            tick();
        end
        oif.out_vld_i = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL ord_drained got=%0d/%b exp=0/0", outstanding, err); end
        oif.out_vld_i = 1'b1;
        #1;
        checks++; if (cif.core_vld_o !== 4'b0) begin errors++; $display("FAIL err_no_vld got=%b exp=0000", cif.core_vld_o); end
        tick();
        oif.out_vld_i = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || outstanding !== 4'd0) begin errors++; $display("FAIL err_set got=%b/%0d exp=1/0", err, outstanding); end
        tick(); tick(); tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cif.core_req_i = '1;
        oif.out_gnt_i = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        checks++; if (outstanding !== 4'd5) begin errors++; $display("FAIL mid_pre got=%0d exp=5", outstanding); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd0 || oif.out_req_o !== 1'b0) begin errors++; $display("FAIL mid_rst got=%0d/%b exp=0/0", outstanding, oif.out_req_o); end
        checks++; if (cif.core_gnt_o !== 4'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_gnt got=%b/%b exp=0000/0", cif.core_gnt_o, err); end
        tick();
        rst_n = 1'b1;
        idle();
        oif.out_vld_i = 1'b1;
        #1;
        checks++; if (cif.core_vld_o !== 4'b0) begin errors++; $display("FAIL mid_stale_vld got=%b exp=0000", cif.core_vld_o); end
        tick();
        oif.out_vld_i = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || outstanding !== 4'd0) begin errors++; $display("FAIL mid_stale_err got=%b/%0d exp=1/0", err, outstanding); end
    endtask

    task automatic test_random();
        req_t mq[NC][$];
        int idq[$];
        int rr, held, w, k;
        bit exp_req, anyne;
        logic [NC-1:0] exp_gnt, exp_vld;
        req_t cur;
        do_reset();
        rr = 0; held = -1; w = 0;
        for (int n = 0; n < 400; n++) begin
            cif.core_req_i = 4'($urandom);
            for (int c = 0; c < NC; c++) begin
                cif.core_addr_i[c]  = $urandom;
                cif.core_wen_i[c]   = 1'($urandom);
                cif.core_be_i[c]    = 4'($urandom);
                cif.core_wdata_i[c] = $urandom;
            end
            oif.out_gnt_i   = ($urandom_range(0, 3) != 0);
            oif.out_vld_i   = (idq.size() > 0) && ($urandom_range(0, 2) == 0);
            oif.out_rdata_i = $urandom;
            #1;
            anyne = 0;
            for (int c = 0; c < NC; c++) begin
                exp_gnt[c] = cif.core_req_i[c] && (mq[c].size() < RD);
                if (mq[c].size() > 0) anyne = 1;
            end
            checks++; if (cif.core_gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", n, cif.core_gnt_o, exp_gnt); end
            exp_req = anyne && (idq.size() < MO);
            checks++; if (oif.out_req_o !== exp_req) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", n, oif.out_req_o, exp_req); end
            if (exp_req) begin
                if (held >= 0) w = held;
                else for (int i = NC - 1; i >= 0; i--) if (mq[(rr + i) % NC].size() > 0) w = (rr + i) % NC;
                cur = {oif.out_addr_o, oif.out_wen_o, oif.out_be_o, oif.out_wdata_o};
                checks++; if (cur !== mq[w][0]) begin errors++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h core=%0d", n, cur, mq[w][0], w); end
            end
            exp_vld = '0;
            if (oif.out_vld_i) begin
                k = idq[0];
                exp_vld[k] = 1'b1;
                checks++; if (cif.core_rdata_o[k] !== oif.out_rdata_i) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", n, cif.core_rdata_o[k], oif.out_rdata_i); end
                void'(idq.pop_front());
            end
            checks++; if (cif.core_vld_o !== exp_vld) begin errors++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", n, cif.core_vld_o, exp_vld); end
            checks++; if (int'(outstanding) != idq.size() + int'(oif.out_vld_i)) begin errors++; $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", n, outstanding, idq.size() + int'(oif.out_vld_i)); end
            if (exp_req && oif.out_gnt_i) begin
                void'(mq[w].pop_front());
                idq.push_back(w);
                rr = (w + 1) % NC;
                held = -1;
            end else if (exp_req) held = w;
            else held = -1;
            for (int c = 0; c < NC; c++)
                if (exp_gnt[c]) mq[c].push_back({cif.core_addr_i[c], cif.core_wen_i[c], cif.core_be_i[c], cif.core_wdata_i[c]});
            tick();
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err got=%b exp=0", err); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_outstanding_cap();
        test_order_error();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tile_remote_port.md
TILE_REMOTE_PORT -- requirements
Module: tile_remote_port

Interface
REQ-001 SHALL have parameter NumCores, default 4: number of core request ports sharing the outgoing port (>=1).
REQ-002 SHALL have parameter ReqDepth, default 2: per-core request FIFO depth in entries (>=1).
REQ-003 SHALL have parameter MaxOutstanding, default 8: maximum granted-but-unanswered outgoing requests (>=1).
REQ-004 SHALL have parameters AddrWidth, default 32, and DataWidth, default 32; BeWidth is DataWidth/8.
REQ-005 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have core-side ports: core_req_i  in  NumCores  request; core_gnt_o  out  NumCores  grant; core_addr_i  in  NumCores x AddrWidth; core_wen_i  in  NumCores  write; core_wdata_i  in  NumCores x DataWidth; core_be_i  in  NumCores x BeWidth.
REQ-007 SHALL have core response ports: core_vld_o  out  NumCores  response valid; core_rdata_o  out  NumCores x DataWidth  response data.
REQ-008 SHALL have outgoing ports: out_req_o  out  1; out_gnt_i  in  1; out_addr_o  out  AddrWidth; out_wen_o  out  1; out_wdata_o  out  DataWidth; out_be_o  out  BeWidth; out_vld_i  in  1; out_rdata_i  in  DataWidth.
REQ-009 SHALL have status ports: outstanding_o  out  clog2(MaxOutstanding+1)  live count; err_o  out  1  sticky unexpected-response flag.

Function
REQ-010 Per core: FIFO of ReqDepth entries holding {addr, wen, be, wdata}.
REQ-011 core_gnt_o[i] = core_req_i[i] AND FIFO i not full; push on core_req_i[i] & core_gnt_o[i].
REQ-012 Full FIFO: core_gnt_o[i]=0, no push, no entry lost or overwritten.
REQ-013 Eligibility: out_req_o = (any FIFO non-empty) AND outstanding < MaxOutstanding.
REQ-014 Arbitration: round-robin over non-empty FIFOs starting at rr pointer; pointer moves to winner+1 (mod NumCores) only on out handshake (out_req_o & out_gnt_i).
REQ-015 While out_req_o=1 and out_gnt_i=0, winner and out_addr/wen/be/wdata SHALL remain stable next cycle (no re-arbitration until handshake).
REQ-016 On handshake: pop winner's FIFO head, push winner index into ID queue (depth MaxOutstanding), outstanding +1.
REQ-017 Minimum latency: request pushed in cycle t is presentable on out_req_o in cycle t+1; no combinational core_req_i -> out_req_o path.
REQ-018 Every handshaked request (read or write) receives exactly one out_vld_i, in issue order.
REQ-019 On out_vld_i with outstanding>0: pop ID queue head k; same cycle core_vld_o[k]=1, core_rdata_o[k]=out_rdata_i; all other core_vld_o=0; outstanding -1.
REQ-020 Handshake and out_vld_i same cycle: outstanding unchanged, ID queue push and pop both performed.
REQ-021 outstanding = MaxOutstanding: out_req_o=0 until a response decrements it; a response in that cycle allows out_req_o next cycle.
REQ-022 out_vld_i with outstanding=0: ignored (no core_vld_o, counter stays 0), err_o set to 1 and held until reset.
REQ-023 core_rdata_o[i] SHALL be don't-care when core_vld_o[i]=0; out_* payload don't-care when out_req_o=0.
REQ-024 NumCores=1: arbiter degenerates to fixed selection; ID queue may hold constant index.

Reset
REQ-025 rst_ni low asynchronously: all FIFOs and ID queue empty, outstanding 0, rr pointer 0, err_o 0.
REQ-026 During and after reset until first push: out_req_o=0, core_gnt_o=0, core_vld_o=0.
REQ-027 Reset mid-transaction discards all buffered and outstanding requests; responses arriving after reset release count as unexpected (REQ-022).

Verification
REQ-028 Single read: NumCores=4, core 2 reads 0x100 at t, out_gnt_i=1 -> out_req_o at t+1 addr 0x100; out_vld_i rdata 0xDEADBEEF -> core_vld_o=4'b0100, core_rdata_o[2]=0xDEADBEEF.
REQ-029 Fairness: all 4 cores keep requesting, out_gnt_i=1, immediate responses -> issue order 0,1,2,3,0,1,... with no core served twice before others.
REQ-030 Backpressure: out_gnt_i=0 for 10 cycles, ReqDepth=2 -> each core accepts exactly 2 requests then core_gnt_o=0; out payload constant throughout.
REQ-031 Outstanding cap: MaxOutstanding=8, out_gnt_i=1, no responses -> exactly 8 handshakes, outstanding_o=8, out_req_o=0; one out_vld_i -> ninth handshake next cycle.
REQ-032 Ordering and error: responses to mixed cores 3,0,3 arrive in issue order with correct routing; extra out_vld_i at outstanding 0 -> err_o=1 sticky, no core_vld_o.
REQ-033 Reset mid-operation: assert rst_ni low with 5 outstanding -> outstanding_o=0, out_req_o=0, core_gnt_o=0 immediately.
